// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshake and iterative 1-bit shifter
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;
  localparam logic [3:0] OP_EQ   = 4'd13;
  localparam logic [3:0] OP_NE   = 4'd14;

  typedef enum logic [1:0] {IDLE, CALC, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] a_q, b_q, shreg, shifted, calc_res;
  logic [SHW-1:0]   cnt, shamt;
  logic             calc_ill, is_shift, accept;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign zero      = (result == '0);
  assign shamt     = b_q[SHW-1:0];
  assign is_shift  = (ctrl_q == OP_SLL) | (ctrl_q == OP_SRL) | (ctrl_q == OP_SRA);

  // SRA fills from the captured sign bit, not the partially shifted register
  always_comb begin
    shifted = {1'b0, shreg[WIDTH-1:1]};
    if (ctrl_q == OP_SLL)
      shifted = {shreg[WIDTH-2:0], 1'b0};
    else if (ctrl_q == OP_SRA)
      shifted = {a_q[WIDTH-1], shreg[WIDTH-1:1]};
  end

  always_comb begin
    calc_res = '0;
    calc_ill = 1'b0;
    case (ctrl_q)
      OP_ADD:  calc_res = a_q + b_q;
      OP_SUB:  calc_res = a_q - b_q;
      OP_AND:  calc_res = a_q & b_q;
      OP_OR:   calc_res = a_q | b_q;
      OP_XOR:  calc_res = a_q ^ b_q;
      OP_SLL, OP_SRL, OP_SRA: calc_res = a_q;
      OP_SLT:  calc_res = WIDTH'($signed(a_q) < $signed(b_q));
      OP_SLTU: calc_res = WIDTH'(a_q < b_q);
      OP_EQ:   calc_res = WIDTH'(a_q == b_q);
      OP_NE:   calc_res = WIDTH'(a_q != b_q);
      default: calc_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = CALC;
      CALC:  state_nxt = (is_shift && shamt != '0) ? SHIFT : DONE;
      SHIFT: if (cnt == SHW'(1)) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = in_valid ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      shreg   <= '0;
      cnt     <= '0;
      result  <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ctrl_q <= alu_ctrl;
        a_q    <= op_a;
        b_q    <= op_b;
      end
      case (state)
        CALC: begin
          if (is_shift && shamt != '0) begin
            shreg <= a_q;
            cnt   <= shamt;
          end else begin
            result  <= calc_res;
            illegal <= calc_ill;
          end
        end
        SHIFT: begin
          shreg <= shifted;
          cnt   <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result  <= shifted;
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a, op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero, illegal, busy;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             ill;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pops the oldest expectation and compares it to the presented output.
  task automatic check_out(input string tag, input int lat);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb_empty: observed 0 entries expected >0", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_lat"}, WIDTH'(lat), WIDTH'(e.lat));
      chk({tag, "_res"}, result, e.res);
      chk({tag, "_zero"}, WIDTH'(zero), WIDTH'(e.res == '0));
      chk({tag, "_ill"}, WIDTH'(illegal), WIDTH'(e.ill));
    end
  endtask

  // Waits for out_valid, counting edges after acceptance; bounded.
  task automatic wait_out(output int k);
    k = 0;
    while (k <= WIDTH + 4) begin
      @(posedge clk); @(negedge clk);
      k++;
      if (out_valid) break;
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] c, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] er,
                       input logic ei, input int lat);
    int k;
    chk({tag, "_in_ready"}, WIDTH'(in_ready), WIDTH'(1));
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    sb.push_back('{er, ei, lat});
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; op_a = ~a; op_b = ~b; alu_ctrl = 4'd7;
    wait_out(k);
    check_out(tag, k);
    @(posedge clk); @(negedge clk);
    chk({tag, "_idle_ov"}, WIDTH'(out_valid), WIDTH'(0));
  endtask

  initial begin
    int k, highs;
    logic [3:0] ill_codes [4];
    logic [WIDTH-1:0] held;
    ill_codes[0] = 4'd5; ill_codes[1] = 4'd6; ill_codes[2] = 4'd7; ill_codes[3] = 4'd15;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, '0);
    chk("rst_zero", WIDTH'(zero), WIDTH'(1));
    chk("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("rst_illegal", WIDTH'(illegal), WIDTH'(0));
    chk("rst_busy", WIDTH'(busy), WIDTH'(0));
    chk("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
    rst_n = 1'b1;
    @(negedge clk);

    do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
    do_op("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);

    // Reset mid-shift: nonzero result above must be cleared, op discarded
    alu_ctrl = 4'd8; op_a = 32'h3; op_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", result, '0);
    chk("mid_rst_zero", WIDTH'(zero), WIDTH'(1));
    chk("mid_rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("mid_rst_busy", WIDTH'(busy), WIDTH'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
    highs = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) highs++;
    end
    chk("post_rst_stale_ov", WIDTH'(highs), WIDTH'(0));

    do_op("xor", 4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0, 1);
    do_op("slt", 4'd11, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1);
    do_op("sltu", 4'd12, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
    do_op("eq", 4'd13, 32'h1234, 32'h1234, 32'h1, 1'b0, 1);
    do_op("ne", 4'd14, 32'h1234, 32'h1234, 32'h0, 1'b0, 1);
    do_op("sra4", 4'd10, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 5);
    do_op("srl4", 4'd9, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 5);
    do_op("sll31", 4'd8, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 32);
    do_op("sll0", 4'd8, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1'b0, 1);

    // Backpressure then back-to-back acceptance from DONE
    out_ready = 1'b0;
    alu_ctrl = 4'd3; op_a = 32'h00F0; op_b = 32'h0F00; in_valid = 1'b1;
    sb.push_back('{32'h0FF0, 1'b0, 1});
    @(posedge clk); @(negedge clk);
    alu_ctrl = 4'd2; op_a = 32'hFF00; op_b = 32'h0FF0;
    wait_out(k);
    check_out("or_bp", k);
    held = result;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("bp_out_valid", WIDTH'(out_valid), WIDTH'(1));
      chk("bp_result", result, held);
      chk("bp_in_ready", WIDTH'(in_ready), WIDTH'(0));
    end
    sb.push_back('{32'h0F00, 1'b0, 1});
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", WIDTH'(in_ready), WIDTH'(1));
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_calc_ov", WIDTH'(out_valid), WIDTH'(0));
    wait_out(k);
    check_out("and_b2b", k);
    @(posedge clk); @(negedge clk);

    foreach (ill_codes[i])
      do_op("illegal", ill_codes[i], 32'h55, 32'h66, 32'h0, 1'b1, 1);
    do_op("add_after_ill", 4'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1);

    chk("sb_drained", WIDTH'(sb.size()), WIDTH'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
